trap_sequencer: RTL and testbench
=================================

TRAP_SEQUENCER -- requirements
Module: trap_sequencer

Interface
REQ-001 SHALL have port clk_i, input, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset_i, input, 1: reset, synchronous and active-high.
REQ-003 SHALL have port boundary_i, input, 1: pipeline at an instruction boundary; events sampled only when high.
REQ-004 SHALL have ports illegal_i, ebreak_i, ecall_i, mret_i, input, 1 each: instruction events, qualified by boundary_i.
REQ-005 SHALL have port take_irq_i, input, 1: interrupt pending and enabled, from the CSR block.
REQ-006 SHALL have ports mtvec_i and mepc_i, input, 64 each: current mtvec and mepc from the CSR block.
REQ-007 SHALL have ports mie_0_o, mie_mpie_o, mpie_mie_o, mpie_1_o, output, 1 each: mstatus update strobes to the CSR block.
REQ-008 SHALL have ports mcause_2_o, mcause_3_o, mcause_11_o, mcause_irq_o, output, 1 each: mcause load strobes and the interrupt flag.
REQ-009 SHALL have ports mepc_ia_o and mepc_pc_o, output, 1 each: mepc load from instruction address or next PC.
REQ-010 SHALL have port pc_load_o, output, 1: one-cycle redirect strobe to fetch.
REQ-011 SHALL have port pc_o, output, 64: redirect target, valid while pc_load_o is high.
REQ-012 SHALL have port busy_o, output, 1: high in any state other than IDLE; the pipeline holds while it is high.

Function
REQ-013 SHALL implement states IDLE, TSAVE, TVEC, RSAVE, RVEC.
REQ-014 In IDLE with boundary_i=1, SHALL select one event, priority illegal_i > ebreak_i > ecall_i > mret_i > take_irq_i, and latch its cause into a 2-bit register.
REQ-015 An exception or interrupt SHALL move IDLE->TSAVE; mret_i SHALL move IDLE->RSAVE; with no event the FSM SHALL stay in IDLE.
REQ-016 Events SHALL be ignored outside IDLE and when boundary_i=0; they are not queued.
REQ-017 TSAVE (1 cycle) SHALL assert mpie_mie_o, mie_0_o, and exactly one of mcause_2_o (illegal), mcause_3_o (ebreak), mcause_11_o (ecall or irq).
REQ-018 In TSAVE, mcause_irq_o SHALL be 1 only for an interrupt.
REQ-019 In TSAVE, mepc_ia_o SHALL be asserted for exceptions and mepc_pc_o for interrupts.
REQ-020 TSAVE SHALL always advance to TVEC.
REQ-021 TVEC (1 cycle) SHALL assert pc_load_o with pc_o = {mtvec_i[63:2],2'b00}, then return to IDLE.
REQ-022 RSAVE (1 cycle) SHALL assert mie_mpie_o and mpie_1_o, then advance to RVEC.
REQ-023 RVEC (1 cycle) SHALL assert pc_load_o with pc_o = {mepc_i[63:2],2'b00}, then return to IDLE.
REQ-024 Latency SHALL be event sample to pc_load_o = 2 cycles, and busy_o SHALL be high for exactly 2 cycles per accepted event.
REQ-025 All strobes SHALL be Moore outputs decoded from state and the cause register only; no input SHALL feed any output combinationally.
REQ-026 Outside their named states, all strobes SHALL be 0 and pc_o SHALL be 0.

Reset
REQ-027 reset_i=1 SHALL force IDLE and clear the cause register on the same edge, including mid-sequence; the pending redirect is discarded.
REQ-028 Outputs SHALL be 0 in the cycle after a reset edge, and busy_o SHALL be 0.
REQ-029 The first event SHALL be accepted in the first cycle with reset_i=0.

Configuration
REQ-030 With macro TRAP_SEQUENCER_VECTORED_EN defined, interrupt redirects with mtvec_i[1:0]=2'b01 SHALL use pc_o = {mtvec_i[63:2],2'b00} + 64'd44 (4*11), wrapping modulo 2^64; exceptions SHALL always use the base.
REQ-031 With TRAP_SEQUENCER_VECTORED_EN undefined, every trap SHALL use the base address regardless of mtvec_i[1:0].

Verification
REQ-032 boundary_i=1, illegal_i=1, mtvec_i=64'hFFFF_FFFF_FFFF_FE00 -> next cycle mcause_2_o, mepc_ia_o, mie_0_o, mpie_mie_o high; following cycle pc_load_o=1, pc_o=64'hFFFF_FFFF_FFFF_FE00.
REQ-033 illegal_i, ecall_i and take_irq_i asserted together -> only mcause_2_o pulses and mcause_irq_o stays 0.
REQ-034 mret_i with mepc_i=64'h8000_0103 -> mie_mpie_o and mpie_1_o pulse, then pc_o=64'h8000_0100 with pc_load_o=1.
REQ-035 take_irq_i with mtvec_i=64'h1001 and the macro defined -> mcause_11_o, mcause_irq_o, mepc_pc_o pulse, then pc_o=64'h102C; with the macro undefined, pc_o=64'h1000.
REQ-036 reset_i raised in the TSAVE cycle -> no pc_load_o pulse, busy_o=0 the next cycle; an ebreak_i with boundary_i=1 during busy_o=1 -> ignored.

Source files
------------

// File: rtl/trap_sequencer.sv
// trap_sequencer: machine-mode trap entry / mret return sequencer.
// Walks IDLE -> TSAVE -> TVEC for exceptions and interrupts, and
// IDLE -> RSAVE -> RVEC for mret, pulsing CSR update strobes and a
// one-cycle fetch redirect. Every output is a registered Moore output.
// Optional feature: define TRAP_SEQUENCER_VECTORED_EN to send interrupts
// to base + 4*11 when mtvec is in vectored mode (mtvec[1:0] == 2'b01).
module trap_sequencer (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        boundary_i,
  input  logic        illegal_i,
  input  logic        ebreak_i,
  input  logic        ecall_i,
  input  logic        mret_i,
  input  logic        take_irq_i,
  input  logic [63:0] mtvec_i,
  input  logic [63:0] mepc_i,
  output logic        mie_0_o,
  output logic        mie_mpie_o,
  output logic        mpie_mie_o,
  output logic        mpie_1_o,
  output logic        mcause_2_o,
  output logic        mcause_3_o,
  output logic        mcause_11_o,
  output logic        mcause_irq_o,
  output logic        mepc_ia_o,
  output logic        mepc_pc_o,
  output logic        pc_load_o,
  output logic [63:0] pc_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {IDLE, TSAVE, TVEC, RSAVE, RVEC} state_t;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'd0;
  localparam logic [1:0] CAUSE_EBREAK  = 2'd1;
  localparam logic [1:0] CAUSE_ECALL   = 2'd2;
  localparam logic [1:0] CAUSE_IRQ     = 2'd3;

  state_t      state;
  logic [1:0]  cause;
  logic        is_exc;
  logic [1:0]  exc_cause;
  logic [63:0] trap_target;
  logic        unused_bits;

  // Low address bits of mepc (and mtvec in the base-only build) are dropped.
  assign unused_bits = ^{mepc_i[1:0], mtvec_i[1:0]};

  // Exception selection: illegal > ebreak > ecall; mret and irq follow.
  always_comb begin
    is_exc    = illegal_i | ebreak_i | ecall_i;
    exc_cause = CAUSE_ECALL;
    if (illegal_i)     exc_cause = CAUSE_ILLEGAL;
    else if (ebreak_i) exc_cause = CAUSE_EBREAK;
  end

  // Trap vector from the latched cause; only interrupts may be vectored.
  always_comb begin
    trap_target = {mtvec_i[63:2], 2'b00};
`ifdef TRAP_SEQUENCER_VECTORED_EN
    if (cause == CAUSE_IRQ && mtvec_i[1:0] == 2'b01)
      trap_target = {mtvec_i[63:2], 2'b00} + 64'd44;
`endif
  end

  // Sequencer state, cause register and registered strobes.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state        <= IDLE;
      cause        <= CAUSE_ILLEGAL;
      mie_0_o      <= 1'b0;
      mie_mpie_o   <= 1'b0;
      mpie_mie_o   <= 1'b0;
      mpie_1_o     <= 1'b0;
      mcause_2_o   <= 1'b0;
      mcause_3_o   <= 1'b0;
      mcause_11_o  <= 1'b0;
      mcause_irq_o <= 1'b0;
      mepc_ia_o    <= 1'b0;
      mepc_pc_o    <= 1'b0;
      pc_load_o    <= 1'b0;
      pc_o         <= 64'd0;
      busy_o       <= 1'b0;
    end else begin
      // Strobes are single-cycle: cleared unless the next state sets them.
      mie_0_o      <= 1'b0;
      mie_mpie_o   <= 1'b0;
      mpie_mie_o   <= 1'b0;
      mpie_1_o     <= 1'b0;
      mcause_2_o   <= 1'b0;
      mcause_3_o   <= 1'b0;
      mcause_11_o  <= 1'b0;
      mcause_irq_o <= 1'b0;
      mepc_ia_o    <= 1'b0;
      mepc_pc_o    <= 1'b0;
      pc_load_o    <= 1'b0;
      pc_o         <= 64'd0;
      busy_o       <= 1'b0;
      case (state)
        IDLE: begin
          if (boundary_i) begin
            if (is_exc || (!mret_i && take_irq_i)) begin
              state        <= TSAVE;
              cause        <= is_exc ? exc_cause : CAUSE_IRQ;
              busy_o       <= 1'b1;
              mie_0_o      <= 1'b1;
              mpie_mie_o   <= 1'b1;
              mcause_2_o   <= is_exc && exc_cause == CAUSE_ILLEGAL;
              mcause_3_o   <= is_exc && exc_cause == CAUSE_EBREAK;
              mcause_11_o  <= !is_exc || exc_cause == CAUSE_ECALL;
              mcause_irq_o <= !is_exc;
              mepc_ia_o    <= is_exc;
              mepc_pc_o    <= !is_exc;
            end else if (mret_i) begin
              state      <= RSAVE;
              busy_o     <= 1'b1;
              mie_mpie_o <= 1'b1;
              mpie_1_o   <= 1'b1;
            end
          end
        end
        TSAVE: begin
          state     <= TVEC;
          busy_o    <= 1'b1;
          pc_load_o <= 1'b1;
          pc_o      <= trap_target;
        end
        RSAVE: begin
          state     <= RVEC;
          busy_o    <= 1'b1;
          pc_load_o <= 1'b1;
          pc_o      <= {mepc_i[63:2], 2'b00};
        end
        TVEC, RVEC: state <= IDLE;
        default:    state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer with a scoreboard of expected output
// vectors. Honours TRAP_SEQUENCER_VECTORED_EN for the vectored-irq targets.
module tb_trap_sequencer;

  logic        clk = 1'b0;
  logic        reset_i, boundary_i, illegal_i, ebreak_i, ecall_i, mret_i, take_irq_i;
  logic [63:0] mtvec_i, mepc_i;
  logic        mie_0_o, mie_mpie_o, mpie_mie_o, mpie_1_o;
  logic        mcause_2_o, mcause_3_o, mcause_11_o, mcause_irq_o;
  logic        mepc_ia_o, mepc_pc_o, pc_load_o, busy_o;
  logic [63:0] pc_o;

  int total = 0;
  int bad   = 0;
  logic [75:0] q[$];
  logic [75:0] exp_v;
  logic [75:0] obs_v;
  logic [63:0] vec_irq_pc;
  logic [63:0] wrap_irq_pc;

  trap_sequencer dut (
    .clk_i(clk), .reset_i(reset_i), .boundary_i(boundary_i),
    .illegal_i(illegal_i), .ebreak_i(ebreak_i), .ecall_i(ecall_i),
    .mret_i(mret_i), .take_irq_i(take_irq_i),
    .mtvec_i(mtvec_i), .mepc_i(mepc_i),
    .mie_0_o(mie_0_o), .mie_mpie_o(mie_mpie_o), .mpie_mie_o(mpie_mie_o),
    .mpie_1_o(mpie_1_o), .mcause_2_o(mcause_2_o), .mcause_3_o(mcause_3_o),
    .mcause_11_o(mcause_11_o), .mcause_irq_o(mcause_irq_o),
    .mepc_ia_o(mepc_ia_o), .mepc_pc_o(mepc_pc_o),
    .pc_load_o(pc_load_o), .pc_o(pc_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Vector layout: {busy, mie_0, mie_mpie, mpie_mie, mpie_1, mcause_2,
  // mcause_3, mcause_11, mcause_irq, mepc_ia, mepc_pc, pc_load, pc[63:0]}
  localparam logic [75:0] V_IDLE = 76'd0;
  localparam logic [75:0] V_RSAVE = {12'b1_0101_0000_000, 64'd0};

  function automatic logic [75:0] v_tsave(input logic c2, c3, c11, irq);
    return {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, c2, c3, c11, irq, ~irq, irq, 1'b0, 64'd0};
  endfunction

  function automatic logic [75:0] v_redirect(input logic [63:0] pc);
    return {1'b1, 10'd0, 1'b1, pc};
  endfunction

  task automatic drive(input logic b, il, eb, ec, mr, irq);
    boundary_i = b; illegal_i = il; ebreak_i = eb;
    ecall_i = ec; mret_i = mr; take_irq_i = irq;
  endtask

  // Push the vector expected after the next edge, then check it.
  task automatic step(input string tag, input logic [75:0] e);
    q.push_back(e);
    @(posedge clk);
    #1;
    total++;
    obs_v = {busy_o, mie_0_o, mie_mpie_o, mpie_mie_o, mpie_1_o, mcause_2_o,
             mcause_3_o, mcause_11_o, mcause_irq_o, mepc_ia_o, mepc_pc_o,
             pc_load_o, pc_o};
    if (q.size() == 0) begin
      bad++;
      $display("FAIL %s scoreboard empty obs=%h", tag, obs_v);
    end else begin
      exp_v = q.pop_front();
      assert (obs_v === exp_v)
      else begin
        bad++;
        $error("FAIL %s obs=%h exp=%h", tag, obs_v, exp_v);
      end
    end
  endtask

  // One accepted event: save cycle, redirect cycle, then back to idle.
  task automatic seq(input string tag, input logic il, eb, ec, mr, irq,
                     input logic [75:0] e1, input logic [75:0] e2);
    drive(1'b1, il, eb, ec, mr, irq);
    step({tag, "_save"}, e1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step({tag, "_redir"}, e2);
    step({tag, "_idle"}, V_IDLE);
  endtask

  initial begin
    #20000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
`ifdef TRAP_SEQUENCER_VECTORED_EN
    vec_irq_pc  = 64'h102C;
    wrap_irq_pc = 64'h0;
`else
    vec_irq_pc  = 64'h1000;
    wrap_irq_pc = 64'hFFFF_FFFF_FFFF_FFD4;
`endif
    reset_i = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    mtvec_i = 64'hFFFF_FFFF_FFFF_FE00;
    mepc_i  = 64'h8000_0103;
    step("reset0", V_IDLE);
    step("reset1", V_IDLE);

    // First cycle out of reset accepts an illegal instruction.
    reset_i = 1'b0;
    seq("illegal", 1, 0, 0, 0, 0, v_tsave(1, 0, 0, 0), v_redirect(64'hFFFF_FFFF_FFFF_FE00));
    // Priority: illegal wins over ecall and interrupt.
    seq("prio_ill", 1, 0, 1, 0, 1, v_tsave(1, 0, 0, 0), v_redirect(64'hFFFF_FFFF_FFFF_FE00));
    seq("ebreak", 0, 1, 0, 0, 0, v_tsave(0, 1, 0, 0), v_redirect(64'hFFFF_FFFF_FFFF_FE00));
    seq("ecall", 0, 0, 1, 0, 1, v_tsave(0, 0, 1, 0), v_redirect(64'hFFFF_FFFF_FFFF_FE00));
    seq("mret", 0, 0, 0, 1, 0, V_RSAVE, v_redirect(64'h8000_0100));
    seq("mret_over_irq", 0, 0, 0, 1, 1, V_RSAVE, v_redirect(64'h8000_0100));

    // Vectored mtvec: interrupt may be offset, exception always at base.
    mtvec_i = 64'h1001;
    seq("irq_vec", 0, 0, 0, 0, 1, v_tsave(0, 0, 1, 1), v_redirect(vec_irq_pc));
    seq("ecall_vec", 0, 0, 1, 0, 0, v_tsave(0, 0, 1, 0), v_redirect(64'h1000));
    mtvec_i = 64'h1002;
    seq("irq_mode2", 0, 0, 0, 0, 1, v_tsave(0, 0, 1, 1), v_redirect(64'h1000));
    mtvec_i = 64'hFFFF_FFFF_FFFF_FFD5;
    seq("irq_wrap", 0, 0, 0, 0, 1, v_tsave(0, 0, 1, 1), v_redirect(wrap_irq_pc));

    // Events without boundary are ignored.
    mtvec_i = 64'h2000;
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step("no_boundary0", V_IDLE);
    step("no_boundary1", V_IDLE);

    // ebreak while busy is dropped, not queued.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("busy_ecall", v_tsave(0, 0, 1, 0));
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("busy_ebreak_tvec", v_redirect(64'h2000));
    step("busy_ebreak_drop", V_IDLE);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("busy_after", V_IDLE);

    // Reset during TSAVE discards the pending redirect.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("rst_mid_save", v_tsave(1, 0, 0, 0));
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset_i = 1'b1;
    step("rst_mid_edge", V_IDLE);
    reset_i = 1'b0;
    step("rst_mid_after", V_IDLE);

    // Normal operation resumes after the mid-sequence reset.
    seq("post_rst_mret", 0, 0, 0, 1, 0, V_RSAVE, v_redirect(64'h8000_0100));

    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain left=%0d", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
